rr_arb4_mux: RTL
================

RR_ARB4_MUX -- requirements
Module: rr_arb4_mux

Interface
REQ-001 The block SHALL expose parameter HOLD_MAX, default 8, meaning the maximum number of cycles one owner keeps the grant while another requester waits; legal range 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 The block SHALL have port req, input, 4 bits: req[i]=1 means requester i wants the shared channel.
REQ-005 The block SHALL have port din, input, 4 bits: din[i] is requester i's 1-bit data.
REQ-006 The block SHALL have port gnt, output, 4 bits: one-hot registered grant; all zero when idle.
REQ-007 The block SHALL have port sel, output, 2 bits: registered index of the current owner; it drives the downstream 4:1 select.
REQ-008 The block SHALL have port busy, output, 1 bit: registered, 1 while any grant is active.
REQ-009 The block SHALL have port dout, output, 1 bit: combinational, equal to din[sel] when busy=1, otherwise 0.

Function
REQ-010 The block SHALL implement two states, IDLE and BUSY, with busy=1 exactly in BUSY.
REQ-011 The block SHALL keep an internal 2-bit priority pointer ptr; the round-robin search order SHALL be ptr, ptr+1, ptr+2, ptr+3, modulo 4.
REQ-012 In IDLE with req!=0, the block SHALL grant the first set req bit in search order at the next edge and enter BUSY; latency is 1 cycle from req sampled to gnt visible.
REQ-013 In IDLE with req==0, the block SHALL remain in IDLE with gnt=0; sel holds its last value.
REQ-014 On every new grant to index k, the block SHALL set sel=k, gnt=1<<k, ptr=(k+1) mod 4, and the hold counter cnt=0.
REQ-015 In BUSY, cnt (8 bits) SHALL increment by 1 each cycle the owner keeps the grant and SHALL saturate at HOLD_MAX-1.
REQ-016 In BUSY, if req[sel]=0 (release) and another req bit is set, the block SHALL grant the next requester in search order at the same edge, with no idle cycle between owners.
REQ-017 In BUSY, if req[sel]=0 and req==0, the block SHALL return to IDLE at the next edge with gnt=0 and busy=0.
REQ-018 In BUSY, if req[sel]=1, cnt==HOLD_MAX-1, and any other req bit is set, the block SHALL preempt and grant the next other requester in search order at the next edge.
REQ-019 In BUSY, if cnt==HOLD_MAX-1 and no other requester is active, the owner SHALL keep the grant indefinitely with cnt saturated.
REQ-020 The current owner SHALL never be chosen by preemption; on release it MAY be regranted only when it is the sole requester, and only after a pass through IDLE.
REQ-021 gnt SHALL never have more than one bit set.
REQ-022 sel SHALL equal the index of the set gnt bit whenever busy=1.
REQ-023 req changes between edges SHALL have no effect until sampled, except on dout, which follows din combinationally.

Reset
REQ-024 When rst=1 at an edge, the block SHALL force state=IDLE, gnt=0, sel=0, busy=0, cnt=0, and ptr=0, overriding all other conditions.
REQ-025 Reset asserted during BUSY SHALL drop the grant at that edge; dout SHALL read 0 from that edge onward.
REQ-026 After rst deasserts, the first grant SHALL follow REQ-012 with ptr=0.

Verification
REQ-027 Reset, then req=4'b0110 held -> one cycle later gnt=0010, sel=1, busy=1; after 8 cycles gnt=0100, sel=2; after 8 more cycles gnt=0010.
REQ-028 Owner 0 alone, din=4'b0001 -> dout=1; drop req[0] while req=4'b1000 -> next edge gnt=1000, sel=3, with no busy=0 cycle in between.
REQ-029 req=4'b0001 held for 20 cycles with HOLD_MAX=8 -> gnt=0001 throughout, cnt saturated at 7; assert req[2] -> next edge gnt=0100.
REQ-030 req=4'b1111 held -> grant sequence 0,1,2,3,0 with each owner held exactly HOLD_MAX cycles; gnt is one-hot on every cycle.
REQ-031 rst pulsed for 1 cycle mid-BUSY with owner 2 -> gnt=0, busy=0, and sel=0 at that edge; with req=4'b1111 still high, gnt=0001 one cycle after rst falls.
REQ-032 Sole owner 1 releases (req=0) -> busy=0 next edge; req=4'b0010 reasserted -> gnt=0010 one cycle later.

Source files
------------

// File: rtl/rr_arb4_mux.sv
// Four-requester round-robin arbiter with bounded hold time, driving a 4:1 data mux.
// The grant, select and busy state are registered; dout follows din combinationally.
module rr_arb4_mux #(
   parameter int unsigned HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] din,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy,
   output logic       dout
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [7:0] CNT_MAX = 8'(HOLD_MAX - 1);

   state_t     state, state_n;
   logic [3:0] gnt_n;
   logic [1:0] sel_n;
   logic [1:0] ptr, ptr_n;
   logic [7:0] cnt, cnt_n;
   logic [3:0] others;
   logic [3:0] mask;
   logic [2:0] pick;

   // Returns {found, index} of the first set mask bit searching from 'from' upward, mod 4.
   function automatic logic [2:0] rr_pick(input logic [3:0] m, input logic [1:0] from);
      logic [1:0] idx;
      rr_pick = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         idx = from + 2'(i);
         if (m[idx] && !rr_pick[2]) rr_pick = {1'b1, idx};
      end
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         sel   <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         sel   <= sel_n;
         ptr   <= ptr_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      sel_n   = sel;
      ptr_n   = ptr;
      cnt_n   = cnt;
      others  = req & ~(4'b0001 << sel);
      // A still-requesting owner is masked out so preemption never reselects it.
      mask    = (state == BUSY && req[sel]) ? others : req;
      pick    = rr_pick(mask, ptr);
      case (state)
         IDLE: begin
            if (pick[2]) begin
               state_n = BUSY;
               gnt_n   = 4'b0001 << pick[1:0];
               sel_n   = pick[1:0];
               ptr_n   = pick[1:0] + 2'd1;
               cnt_n   = '0;
            end
         end
         BUSY: begin
            if (!req[sel] || (cnt == CNT_MAX && others != '0)) begin
               if (pick[2]) begin
                  gnt_n = 4'b0001 << pick[1:0];
                  sel_n = pick[1:0];
                  ptr_n = pick[1:0] + 2'd1;
                  cnt_n = '0;
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
               end
            end else if (cnt != CNT_MAX) begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      endcase
   end

   always_comb begin
      busy = (state == BUSY);
      dout = busy ? din[sel] : 1'b0;
   end

endmodule
